// File: rtl/aca_spec_recovery_ctrl.sv
// Sequencer for a windowed-carry (almost-correct) adder: one speculative pass plus a
// conservative error flag, with optional block-serial exact recomputation of flagged results.
module aca_spec_recovery_ctrl #(
  parameter int WIDTH  = 32,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] input1_i,
  input  logic [WIDTH-1:0] input2_i,
  input  logic             recover_en_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             err_detect_o,
  output logic             corrected_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int NBLK  = WIDTH / WINDOW;
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EVAL    = 2'd1,
    S_RECOVER = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  // Each carry only sees the WINDOW bits below it, with zero carry-in at the window base.
  function automatic logic [WIDTH:0] approx_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;
    logic             cw;
    p = a ^ b;
    g = a & b;
    c = {(WIDTH+1){1'b0}};
    for (int i = 1; i <= WIDTH; i++) begin
      cw = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
        cw = ((k < i) && (k >= i - WINDOW)) ? (g[k] | (p[k] & cw)) : cw;
      end
      c[i] = cw;
    end
    return {c[WIDTH], p ^ c[WIDTH-1:0]};
  endfunction

  // Any WINDOW-long propagate run starting above bit 0 may hide a carry the window cannot see.
  function automatic logic spec_flag(input logic [WIDTH-1:0] p);
    logic f;
    f = 1'b0;
    for (int j = 1; j <= WIDTH - WINDOW; j++) begin
      f = f | (&p[j +: WINDOW]);
    end
    return f;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rec;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_err;
  logic             r_corr;
  logic             r_valid;
  logic             r_in_ready;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-1:0] r_blk;
  logic             r_cy;

  logic [WIDTH:0]   w_approx;
  logic             w_flag;
  logic [WINDOW:0]  w_blk_sum;
  logic             w_last_blk;

  assign w_approx   = approx_add(r_a, r_b);
  assign w_flag     = spec_flag(r_a ^ r_b);
  assign w_blk_sum  = {1'b0, r_a[r_blk*WINDOW +: WINDOW]} + {1'b0, r_b[r_blk*WINDOW +: WINDOW]}
                    + {{WINDOW{1'b0}}, r_cy};
  assign w_last_blk = (r_blk == BLK_W'(NBLK - 1));

  // Control FSM with all handshake and result outputs registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_rec      <= 1'b0;
      r_sum      <= {WIDTH{1'b0}};
      r_carry    <= 1'b0;
      r_err      <= 1'b0;
      r_corr     <= 1'b0;
      r_valid    <= 1'b0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_cnt      <= {CNT_W{1'b0}};
      r_blk      <= {BLK_W{1'b0}};
      r_cy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_a        <= input1_i;
            r_b        <= input2_i;
            r_rec      <= recover_en_i;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (w_flag && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (w_flag && r_rec) begin
            r_blk   <= {BLK_W{1'b0}};
            r_cy    <= 1'b0;
            r_state <= S_RECOVER;
          end else begin
            r_sum   <= w_approx[WIDTH-1:0];
            r_carry <= w_approx[WIDTH];
            r_err   <= w_flag;
            r_corr  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_RECOVER: begin
          r_sum[r_blk*WINDOW +: WINDOW] <= w_blk_sum[WINDOW-1:0];
          r_cy                          <= w_blk_sum[WINDOW];
          if (w_last_blk) begin
            r_carry <= w_blk_sum[WINDOW];
            r_err   <= 1'b1;
            r_corr  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end else begin
            r_blk <= r_blk + {{(BLK_W-1){1'b0}}, 1'b1};
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_corr     <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_valid    <= 1'b0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = r_in_ready;
  assign out_valid_o  = r_valid;
  assign sum_o        = r_sum;
  assign carry_o      = r_carry;
  assign err_detect_o = r_err;
  assign corrected_o  = r_corr;
  assign busy_o       = r_busy;
  assign err_count_o  = r_cnt;

endmodule

// File: tb/tb_aca_spec_recovery_ctrl.sv
// Randomized self-checking bench for aca_spec_recovery_ctrl against an arithmetic reference model.
module tb_aca_spec_recovery_ctrl;

  localparam int W   = 32;
  localparam int WIN = 8;
  localparam int NB  = W / WIN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, rec_en, out_valid, out_ready;
  logic [W-1:0]  a_i, b_i, sum;
  logic          carry, err, corr, busy;
  logic [15:0]   cnt;

  logic          d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [W-1:0]  d2_sum;
  logic          d2_carry, d2_err, d2_corr, d2_busy;
  logic [1:0]    d2_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  aca_spec_recovery_ctrl #(.WIDTH(W), .WINDOW(WIN), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .input1_i(a_i), .input2_i(b_i), .recover_en_i(rec_en), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .sum_o(sum), .carry_o(carry), .err_detect_o(err),
    .corrected_o(corr), .busy_o(busy), .err_count_o(cnt)
  );

  aca_spec_recovery_ctrl #(.WIDTH(W), .WINDOW(WIN), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(d2_in_valid), .in_ready_o(d2_in_ready),
    .input1_i(32'h0000FF01), .input2_i(32'h000000FF), .recover_en_i(1'b0),
    .out_valid_o(d2_out_valid), .out_ready_i(d2_out_ready), .sum_o(d2_sum), .carry_o(d2_carry),
    .err_detect_o(d2_err), .corrected_o(d2_corr), .busy_o(d2_busy), .err_count_o(d2_cnt)
  );

  // Approximate sum: carry into bit i is the carry out of adding the window values as integers.
  function automatic logic [W:0] m_approx(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]  r;
    logic [63:0] wa, wb, mask;
    int          lo, n;
    logic        c;
    r = {(W+1){1'b0}};
    for (int i = 0; i <= W; i++) begin
      lo = (i > WIN) ? i - WIN : 0;
      n  = i - lo;
      if (n == 0) c = 1'b0;
      else begin
        mask = (64'd1 << n) - 64'd1;
        wa   = ({32'd0, a} >> lo) & mask;
        wb   = ({32'd0, b} >> lo) & mask;
        c    = (((wa + wb) >> n) != 64'd0);
      end
      if (i < W) r[i] = a[i] ^ b[i] ^ c;
      else       r[W] = c;
    end
    return r;
  endfunction

  function automatic logic m_flag(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    logic         f;
    p = a ^ b;
    f = 1'b0;
    for (int j = 1; j <= W - WIN; j++) begin
      if (((p >> j) & 32'hFF) == 32'hFF) f = 1'b1;
    end
    return f;
  endfunction

  // Issues one operation, waits (bounded) for the result, samples it and completes the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic rec,
                        output logic [W-1:0] s, output logic c, output logic e, output logic k,
                        output int lat, output logic [15:0] n);
    in_valid = 1'b1; a_i = a; b_i = b; rec_en = rec;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum; c = carry; e = err; k = corr; n = cnt;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else n_pass++;
    n_total++; if ({sum, carry, err, corr, busy} !== {W+4{1'b0}})
      $display("FAIL rst_outputs got %h/%b%b%b%b exp 0", sum, carry, err, corr, busy); else n_pass++;
    n_total++; if (cnt !== 16'd0) $display("FAIL rst_count got %0d exp 0", cnt); else n_pass++;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [4], tb [4], ts [4];
    logic         tr [4], tc [4], te [4], tk [4];
    int           tl [4];
    logic [W-1:0] s;
    logic         c, e, k;
    int           lat;
    logic [15:0]  n;
    ta = '{32'h00000012, 32'h0000FF01, 32'h0000FF01, 32'hFFFFFFFF};
    tb = '{32'h00000034, 32'h000000FF, 32'h000000FF, 32'h00000001};
    tr = '{1'b0, 1'b1, 1'b0, 1'b1};
    ts = '{32'h00000046, 32'h00010000, 32'h0000FE00, 32'h00000000};
    tc = '{1'b0, 1'b0, 1'b0, 1'b1};
    te = '{1'b0, 1'b1, 1'b1, 1'b1};
    tk = '{1'b0, 1'b1, 1'b0, 1'b1};
    tl = '{2, 6, 2, 6};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tr[i], s, c, e, k, lat, n);
      exp_cnt += int'(te[i]);
      n_total++; if (s !== ts[i]) $display("FAIL dir%0d_sum got %h exp %h", i, s, ts[i]); else n_pass++;
      n_total++; if ({c, e, k} !== {tc[i], te[i], tk[i]})
        $display("FAIL dir%0d_flags got %b%b%b exp %b%b%b", i, c, e, k, tc[i], te[i], tk[i]); else n_pass++;
      n_total++; if (lat + 1 !== tl[i]) $display("FAIL dir%0d_latency got t+%0d exp t+%0d", i, lat + 1, tl[i]); else n_pass++;
      n_total++; if (n !== 16'(exp_cnt)) $display("FAIL dir%0d_count got %0d exp %0d", i, n, exp_cnt); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, s, es;
    logic         rec, c, e, k, fl, ec;
    logic [W:0]   ap, ex;
    int           lat, el;
    logic [15:0]  n;
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      rec = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       b = $urandom;
        1:       b = ~a ^ (32'h1 << $urandom_range(0, 31));
        default: b = ~a & $urandom;
      endcase
      fl = m_flag(a, b);
      ap = m_approx(a, b);
      ex = {1'b0, a} + {1'b0, b};
      if (fl && rec) begin {ec, es} = ex; el = 2 + NB; end
      else           begin {ec, es} = ap; el = 2; end
      exp_cnt += int'(fl);
      run_op(a, b, rec, s, c, e, k, lat, n);
      n_total++; if ({c, s} !== {ec, es})
        $display("FAIL rnd%0d_sum a=%h b=%h got %b_%h exp %b_%h", i, a, b, c, s, ec, es); else n_pass++;
      n_total++; if ({e, k} !== {fl, fl & rec})
        $display("FAIL rnd%0d_flags got %b%b exp %b%b", i, e, k, fl, fl & rec); else n_pass++;
      n_total++; if (lat + 1 !== el) $display("FAIL rnd%0d_latency got t+%0d exp t+%0d", i, lat + 1, el); else n_pass++;
      n_total++; if (n !== 16'(exp_cnt)) $display("FAIL rnd%0d_count got %0d exp %0d", i, n, exp_cnt); else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    in_valid = 1'b1; a_i = 32'h00000012; b_i = 32'h00000034; rec_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a_i = $urandom; b_i = $urandom; rec_en = 1'b1;
      n_total++; if ({out_valid, in_ready, busy} !== 3'b101)
        $display("FAIL bp%0d_hs got v%b r%b b%b exp v1 r0 b1", i, out_valid, in_ready, busy); else n_pass++;
      n_total++; if ({sum, carry, err, corr} !== {32'h00000046, 3'b000})
        $display("FAIL bp%0d_hold got %h %b%b%b exp 00000046 000", i, sum, carry, err, corr); else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++; if ({out_valid, in_ready, err, corr, busy} !== 5'b01000)
      $display("FAIL bp_release got %b%b%b%b%b exp 01000", out_valid, in_ready, err, corr, busy); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++; if ({out_valid, busy} !== 2'b00)
      $display("FAIL bp_no_latch got v%b b%b exp 00", out_valid, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_recover;
    in_valid = 1'b1; a_i = 32'h0000FF01; b_i = 32'h000000FF; rec_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({out_valid, in_ready, busy, err, corr, carry} !== 6'b010000)
      $display("FAIL mid_rst_ctrl got %b%b%b%b%b%b exp 010000", out_valid, in_ready, busy, err, corr, carry); else n_pass++;
    n_total++; if ({sum, cnt} !== {W+16{1'b0}}) $display("FAIL mid_rst_data got %h %0d exp 0 0", sum, cnt); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    int lat;
    for (int i = 0; i < 4; i++) begin
      d2_in_valid = 1'b1;
      @(posedge clk); #1;
      d2_in_valid = 1'b0;
      lat = 0;
      while (!d2_out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      n_total++; if ({d2_out_valid, d2_err, d2_sum} !== {2'b11, 32'h0000FE00})
        $display("FAIL sat%0d_result got v%b e%b %h exp v1 e1 0000fe00", i, d2_out_valid, d2_err, d2_sum); else n_pass++;
      n_total++; if (d2_cnt !== 2'((i + 1 > 3) ? 3 : i + 1))
        $display("FAIL sat%0d_count got %0d exp %0d", i, d2_cnt, (i + 1 > 3) ? 3 : i + 1); else n_pass++;
      d2_out_ready = 1'b1;
      @(posedge clk); #1;
      d2_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rec_en = 1'b0;
    a_i = '0; b_i = '0;
    d2_in_valid = 1'b0; d2_out_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_recover();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
